// File: rtl/phase_sweep_ctrl.sv
// rtl/phase_sweep_ctrl.sv - phase sweep sequencer: steps DCM phase, waits for stable lock, triggers AES runs
// One measurement point = set phase, settle on consecutive lock, trigger the core reps times, advance.
module phase_sweep_ctrl #(
    parameter int unsigned SETTLE_CYC = 16
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] phase_min,
    input  logic [7:0] phase_max,
    input  logic [7:0] step,
    input  logic [7:0] reps,
    input  logic       locked,
    input  logic       enc_done,
    output logic [7:0] phase,
    output logic       trig,
    output logic       busy,
    output logic       done,
    output logic [7:0] rep_idx
);

    localparam logic [7:0] SETTLE_TGT = 8'(SETTLE_CYC);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        TRIG,
        WAIT_DONE,
        ADVANCE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] phase_q, phase_d;
    logic [7:0] max_q, max_d;
    logic [7:0] step_q, step_d;
    logic [7:0] reps_q, reps_d;
    logic [7:0] rep_idx_q, rep_idx_d;
    logic [7:0] settle_cnt_q, settle_cnt_d;
    logic       trig_q, trig_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [7:0] step_eff;
    logic [7:0] last_rep;
    logic [8:0] next_sum;

    // Zero step / zero reps behave as one; the 9-bit sum exposes wrap past 255.
    always_comb begin
        step_eff = (step_q == 8'd0) ? 8'd1 : step_q;
        last_rep = (reps_q == 8'd0) ? 8'd0 : (reps_q - 8'd1);
        next_sum = {1'b0, phase_q} + {1'b0, step_eff};
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        max_d        = max_q;
        step_d       = step_q;
        reps_d       = reps_q;
        rep_idx_d    = rep_idx_q;
        settle_cnt_d = settle_cnt_q;
        busy_d       = busy_q;
        trig_d       = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    phase_d      = phase_min;
                    max_d        = phase_max;
                    step_d       = step;
                    reps_d       = reps;
                    rep_idx_d    = 8'd0;
                    settle_cnt_d = 8'd0;
                    busy_d       = 1'b1;
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                // A single-cycle lock blip between DCM steps must not count as settled.
                if (settle_cnt_q == SETTLE_TGT) begin
                    state_d = TRIG;
                    trig_d  = 1'b1;
                end else if (locked) begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                end else begin
                    settle_cnt_d = 8'd0;
                end
            end
            TRIG: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (enc_done) begin
                    if (rep_idx_q < last_rep) begin
                        rep_idx_d = rep_idx_q + 8'd1;
                        state_d   = TRIG;
                        trig_d    = 1'b1;
                    end else begin
                        state_d = ADVANCE;
                    end
                end
            end
            ADVANCE: begin
                if (next_sum > {1'b0, max_q}) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    phase_d      = next_sum[7:0];
                    rep_idx_d    = 8'd0;
                    settle_cnt_d = 8'd0;
                    state_d      = SETTLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Abort overrides whatever the state decided; phase is left where it was.
        if (abort && (state_q != IDLE)) begin
            state_d      = IDLE;
            phase_d      = phase_q;
            rep_idx_d    = rep_idx_q;
            settle_cnt_d = 8'd0;
            busy_d       = 1'b0;
            trig_d       = 1'b0;
            done_d       = 1'b0;
        end
    end

    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            phase_q      <= 8'd0;
            max_q        <= 8'd0;
            step_q       <= 8'd0;
            reps_q       <= 8'd0;
            rep_idx_q    <= 8'd0;
            settle_cnt_q <= 8'd0;
            trig_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            max_q        <= max_d;
            step_q       <= step_d;
            reps_q       <= reps_d;
            rep_idx_q    <= rep_idx_d;
            settle_cnt_q <= settle_cnt_d;
            trig_q       <= trig_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign phase   = phase_q;
    assign trig    = trig_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rep_idx = rep_idx_q;

endmodule

// File: tb/tb_phase_sweep_ctrl.sv
// tb/tb_phase_sweep_ctrl.sv - scoreboard bench for phase_sweep_ctrl
module tb_phase_sweep_ctrl;

    localparam int SC = 16;

    logic       clkin = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] phase_min;
    logic [7:0] phase_max;
    logic [7:0] step;
    logic [7:0] reps;
    logic       locked;
    logic       enc_done;
    logic [7:0] phase;
    logic       trig;
    logic       busy;
    logic       done;
    logic [7:0] rep_idx;

    phase_sweep_ctrl #(.SETTLE_CYC(SC)) dut (
        .clkin     (clkin),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .phase_min (phase_min),
        .phase_max (phase_max),
        .step      (step),
        .reps      (reps),
        .locked    (locked),
        .enc_done  (enc_done),
        .phase     (phase),
        .trig      (trig),
        .busy      (busy),
        .done      (done),
        .rep_idx   (rep_idx)
    );

    always #5 clkin = ~clkin;

    int tests = 0;
    int fails = 0;

    task automatic check_eq(input string nm, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: actual %0d required %0d", nm, act, req);
        end
    endtask

    task automatic check_ge(input string nm, input int act, input int req);
        tests++;
        if (act < req) begin
            fails++;
            $display("FAIL %s: actual %0d required at least %0d", nm, act, req);
        end
    endtask

    typedef struct {
        bit is_done;
        int ph;
        int rep;
    } ev_t;

    ev_t exp_q[$];

    // Reference: list every (phase, rep) trigger of the sweep, then the done with final phase.
    task automatic model_sweep(input int mn, input int mx, input int st, input int rp, output int last);
        int s;
        int r;
        int p;
        ev_t e;
        s = (st == 0) ? 1 : st;
        r = (rp == 0) ? 1 : rp;
        p = mn;
        while (1) begin
            for (int i = 0; i < r; i++) begin
                e.is_done = 0; e.ph = p; e.rep = i;
                exp_q.push_back(e);
            end
            if ((p + s > mx) || (p + s > 255)) break;
            p = p + s;
        end
        e.is_done = 1; e.ph = p; e.rep = 0;
        exp_q.push_back(e);
        last = p;
    endtask

    // Lock source: 0 steady high, 1 toggling, 2 mostly high with random drops.
    int lock_mode = 0;
    initial begin
        locked = 1'b1;
        forever begin
            @(posedge clkin);
            #1;
            case (lock_mode)
                1:       locked = ~locked;
                2:       locked = ($urandom_range(0, 15) != 0);
                default: locked = 1'b1;
            endcase
        end
    end

    // AES core stand-in: enc_done a few cycles after each trig.
    bit long_mode = 0;
    initial begin
        int cd;
        cd = 0;
        enc_done = 1'b0;
        forever begin
            @(posedge clkin);
            #1;
            enc_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) enc_done = 1'b1;
            end
            if (trig) cd = long_mode ? 12 : int'($urandom_range(1, 5));
        end
    end

    // Monitor: pop expected events as the DUT presents trig/done.
    int   done_cnt = 0;
    int   run_cnt = 0, run_d1 = 0, run_d2 = 0;
    logic prev_trig = 1'b0, prev_enc = 1'b0, prev_busy = 1'b0;
    int   prev_phase = 0;
    always @(negedge clkin) begin
        ev_t ev;
        if (trig) begin
            check_eq("trig_gap", int'(prev_trig), 0);
            check_ge("trig_expected", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                ev = exp_q.pop_front();
                check_eq("trig_not_done", int'(ev.is_done), 0);
                check_eq("trig_phase", int'(phase), ev.ph);
                check_eq("trig_rep_idx", int'(rep_idx), ev.rep);
            end
            if (rep_idx == 8'd0) check_ge("settle_run", run_d2, SC);
            else check_eq("no_resettle", int'(prev_enc), 1);
        end
        if (done) begin
            done_cnt++;
            check_eq("done_busy_low", int'(busy), 0);
            check_ge("done_expected", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                ev = exp_q.pop_front();
                check_eq("done_is_done", int'(ev.is_done), 1);
                check_eq("done_phase", int'(phase), ev.ph);
            end
        end
        if ((int'(phase) != prev_phase) || (busy && !prev_busy)) run_cnt = 0;
        run_cnt = locked ? run_cnt + 1 : 0;
        run_d2 = run_d1;
        run_d1 = run_cnt;
        prev_trig = trig;
        prev_enc = enc_done;
        prev_phase = int'(phase);
        prev_busy = busy;
    end

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic run_sweep(input int mn, input int mx, input int st, input int rp,
                             input int mode, input int glitch, input int restart_at,
                             output int lat);
        int last;
        int n;
        int d0;
        d0 = done_cnt;
        model_sweep(mn, mx, st, rp, last);
        phase_min = 8'(mn); phase_max = 8'(mx); step = 8'(st); reps = 8'(rp);
        lock_mode = (glitch > 0) ? 1 : mode;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        n = 0;
        while (n < 4000) begin
            tick();
            n++;
            start = (n == restart_at);
            if (n == restart_at) begin
                phase_min = 8'd100; phase_max = 8'd120; step = 8'd2; reps = 8'd2;
            end
            if (n == glitch) lock_mode = mode;
            if (trig && lat < 0) lat = n;
            if (!busy) break;
        end
        start = 1'b0;
        lock_mode = 0;
        check_eq("sweep_finished", int'(busy), 0);
        tick();
        check_eq("final_phase", int'(phase), last);
        check_eq("done_once", done_cnt - d0, 1);
        check_eq("events_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int lat;
        int n;
        int d0;
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        phase_min = 8'd0; phase_max = 8'd0; step = 8'd0; reps = 8'd0;
        repeat (3) tick();
        check_eq("rst_phase", int'(phase), 0);
        check_eq("rst_trig", int'(trig), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_rep_idx", int'(rep_idx), 0);
        rst = 1'b1;
        tick();

        // basic sweep 10..12, exact first-trigger latency
        run_sweep(10, 12, 1, 1, 0, 0, -1, lat);
        check_eq("basic_latency", lat, SC + 1);

        // settle glitch: toggling lock for 20 cycles
        run_sweep(3, 3, 1, 1, 0, 20, -1, lat);
        check_ge("glitch_latency", lat, 20 + SC);

        // overflow past 255 and zero step
        run_sweep(250, 255, 4, 1, 0, 0, -1, lat);
        run_sweep(7, 7, 0, 1, 0, 0, -1, lat);

        // repetitions, and reps=0 as one
        run_sweep(9, 9, 1, 3, 0, 0, -1, lat);
        run_sweep(9, 10, 1, 0, 0, 0, -1, lat);

        // start while busy (with new inputs), and min above max
        run_sweep(30, 31, 1, 1, 0, 0, 5, lat);
        run_sweep(20, 5, 1, 1, 0, 0, -1, lat);

        // abort while waiting for enc_done
        d0 = done_cnt;
        long_mode = 1;
        begin
            ev_t e;
            e.is_done = 0; e.ph = 40; e.rep = 0;
            exp_q.push_back(e);
        end
        phase_min = 8'd40; phase_max = 8'd50; step = 8'd1; reps = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!trig && n < 200) begin
            tick();
            n++;
        end
        check_eq("abort_saw_trig", int'(trig), 1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_phase", int'(phase), 40);
        check_eq("abort_trig", int'(trig), 0);
        check_eq("abort_done", int'(done), 0);
        repeat (25) tick();
        check_eq("abort_no_done", done_cnt - d0, 0);
        check_eq("abort_events_left", exp_q.size(), 0);
        exp_q.delete();
        long_mode = 0;

        // asynchronous reset mid-settle
        phase_min = 8'd60; phase_max = 8'd70; step = 8'd1; reps = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check_eq("pre_reset_busy", int'(busy), 1);
        #2 rst = 1'b0;
        #1;
        check_eq("async_rst_phase", int'(phase), 0);
        check_eq("async_rst_busy", int'(busy), 0);
        check_eq("async_rst_rep_idx", int'(rep_idx), 0);
        tick();
        rst = 1'b1;
        repeat (30) tick();
        check_eq("post_reset_idle", int'(busy), 0);

        // start and abort together in IDLE: abort wins
        d0 = done_cnt;
        phase_min = 8'd80; phase_max = 8'd80;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check_eq("start_abort_busy", int'(busy), 0);
        repeat (25) tick();
        check_eq("start_abort_no_done", done_cnt - d0, 0);

        // randomized sweeps with random lock drops
        for (int k = 0; k < 20; k++) begin
            int mn;
            int mx;
            mn = int'($urandom_range(0, 255));
            mx = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 255))
                                              : mn + int'($urandom_range(0, 6));
            if (mx > 255) mx = 255;
            run_sweep(mn, mx, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 2, 0, -1, lat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/phase_sweep_ctrl.md
# phase_sweep_ctrl

Sweep sequencer that drives the 8-bit target phase of the variable-phase DCM wrapper and launches one AES encryption per phase point once the DCM has settled. It sits directly upstream of the DCM wrapper: its `phase` output feeds the wrapper's `phase` input, and it consumes the wrapper's `locked_out` as its settle indication. Each point is a measurement: set phase, wait for a stable lock, trigger the core `reps` times, then advance by `step` until `phase_max` is passed.

## Interface
- SETTLE_CYC, 16: consecutive cycles `locked` must be high before a trigger is issued (legal range 2..255).
- clkin  in  1  single clock, same net as the DCM wrapper's `clkin`.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a sweep; ignored while `busy`.
- abort  in  1  stops a running sweep; takes priority over every other input except `rst`.
- phase_min  in  8  first phase point.
- phase_max  in  8  last permitted phase point (inclusive).
- step  in  8  phase increment; 0 is treated as 1.
- reps  in  8  encryptions per phase point; 0 is treated as 1.
- locked  in  1  DCM wrapper `locked_out`.
- enc_done  in  1  one-cycle pulse from the AES core, marking the end of an encryption.
- phase  out  8  target phase to the DCM wrapper.
- trig  out  1  one-cycle encryption start pulse.
- busy  out  1  high from the accepted `start` until the sweep ends.
- done  out  1  one-cycle pulse when the sweep completes normally (not on abort).
- rep_idx  out  8  index of the current encryption within the point, 0-based.

## Operation
- FSM states: IDLE, SETTLE, TRIG, WAIT_DONE, ADVANCE.
- On the edge where `start` is accepted, the block:
  - latches `phase_min`, `phase_max`, `step` and `reps`; input changes during a sweep have no effect;
  - sets `phase` to `phase_min`, `rep_idx` to 0, `busy` to 1;
  - clears the settle counter and enters SETTLE.
- SETTLE:
  - the settle counter increments on each cycle `locked` is 1 and clears on each cycle `locked` is 0;
  - when the counter reaches SETTLE_CYC, go to TRIG.
  - The wrapper raises `locked` for a single cycle between individual phase steps, so the consecutive-high rule is mandatory.
- TRIG: `trig` is 1 for exactly this one cycle; go to WAIT_DONE.
- WAIT_DONE: wait for `enc_done`. An `enc_done` arriving while in TRIG or SETTLE is ignored. On `enc_done`:
  - if `rep_idx` is less than reps−1, increment `rep_idx` and go to TRIG; there is no re-settle, because `phase` is unchanged;
  - otherwise go to ADVANCE.
- ADVANCE: compute the next phase as a 9-bit sum, `phase` + step.
  - If the sum is greater than `phase_max`, or bit 8 is set: end the sweep. `done` pulses for 1 cycle, `busy` drops to 0, the FSM returns to IDLE, and `phase` holds its last value.
  - Otherwise: `phase` takes the sum, `rep_idx` resets to 0, the settle counter clears, and the FSM goes to SETTLE.
- If `phase_min` is greater than `phase_max`, the sweep still measures the single point `phase_min`, then ends.
- `abort` in any non-IDLE state: on the next edge the FSM returns to IDLE with `busy` 0, `trig` 0 and no `done` pulse; `phase` holds its value.
- If `start` and `abort` are both high in IDLE, `abort` wins and the start is dropped.
- Reset values: `phase` 0, `trig` 0, `busy` 0, `done` 0, `rep_idx` 0, state IDLE, settle counter 0.
- Reset mid-sweep: all outputs return to their reset values immediately (asynchronously), with no `done` pulse.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- `start` accepted at edge E0: `phase` and `busy` are valid after E0.
- With `locked` already high, `trig` rises at edge E0+SETTLE_CYC+1 and stays high for 1 cycle.
- `enc_done` at edge Ed, when a repetition remains: `trig` rises at edge Ed+1.
- `enc_done` at edge Ed on the last repetition: ADVANCE occupies edge Ed+1. The new `phase`, or the `done` pulse, is valid after edge Ed+2.
- `done` and `busy` falling change on the same edge.
- `trig` is never high in two consecutive cycles.

## Test plan
- Basic sweep, with `locked` tied high:
  - stimulus: min=10, max=12, step=1, reps=1, SETTLE_CYC=16, `enc_done` 5 cycles after each `trig`;
  - required: three trig pulses, at phase 10, 11, 12; `done` once; `phase` ends at 12.
- Settle glitch:
  - stimulus: `locked` toggles 1,0 every cycle for 20 cycles after start, then stays high;
  - required: no trig until 16 consecutive high cycles have elapsed.
- Overflow and step:
  - stimulus 1: min=250, max=255, step=4;
  - required 1: points 250 and 254 only (258 sets bit 8 and ends the sweep);
  - stimulus 2: step=0, min=max=7;
  - required 2: exactly one point, at 7.
- Repetition:
  - stimulus: reps=3;
  - required: `rep_idx` goes 0,1,2 with three trigs at the same phase and no re-settle between them; reps=0 gives one trig.
- Abort and reset:
  - stimulus 1: `abort` while in WAIT_DONE;
  - required 1: IDLE next cycle, `busy`=0, no `done`, `phase` held;
  - stimulus 2: `rst` low mid-SETTLE;
  - required 2: `phase`=0 and `busy`=0 immediately, without waiting for a clock edge.
- Start while busy, and min greater than max:
  - stimulus 1: a second `start` during a sweep;
  - required 1: it is ignored;
  - stimulus 2: min=20, max=5;
  - required 2: a single point at 20, then `done`.
